regfile_sequencer: RTL and testbench
====================================

// Module: regfile_sequencer
// PURPOSE
//  Multi-cycle controller that sequences the 8x16 register file and ALU datapath for one instruction at a time.
//  Latches a 16-bit instruction on start, then steps through read-A, read-B, compute and write-back states.
//  Each state drives the regfile read/write ports and the datapath load/select strobes.
//  Sits between instruction fetch (or testbench switches) and the datapath; signals completion via w.
// PARAMETERS
//  DATA_W   16  datapath/instruction width
//  REG_AW   3   register index width (8 registers)
// PORTS
//  clk       in   1       rising-edge clock, sole clock domain
//  reset_n   in   1       synchronous, active-low reset
//  s         in   1       start; sampled only while w=1
//  instr     in   DATA_W  instruction; captured into IR on s&w
//  w         out  1       1 = idle/ready (state WAIT)
//  readnum   out  REG_AW  regfile read index
//  writenum  out  REG_AW  regfile write index
//  write     out  1       regfile write enable
//  loada     out  1       load A register
//  loadb     out  1       load B register
//  loadc     out  1       load C register
//  loads     out  1       load status flags
//  asel      out  1       1 = ALU A input forced to 0
//  bsel      out  1       1 = ALU B input = sximm5 (reserved, driven 0 in this ISA subset)
//  vsel      out  2       writeback mux: 00=C, 01=sximm8
//  shift     out  2       shifter op = IR[4:3] (forced 00 for CMP/AND/MVN per ALU rules below)
//  alu_op    out  2       ALU op = IR[12:11] (ADD=00 for MOV reg)
//  sximm8    out  DATA_W  sign-extended IR[7:0]
//  err       out  1       only with REGSEQ_TRAP_EN; otherwise tied 0
// BEHAVIOUR
//  IR fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
//  Reset (reset_n=0 at edge): state=WAIT, IR=0, w=1, all strobes/enables 0, indices 0, err=0.
//  Applies from any state mid-instruction; a pending write is abandoned.
//  Outputs are Moore: decoded from state+IR only, never from s/instr.
//  WAIT: w=1. If s=1: IR<=instr, go DECODE. s while w=0 is ignored.
//  DECODE:
//   - 110/10 (MOV imm) -> WR_IMM.
//   - 110/00 (MOV reg) -> GET_B.
//   - 101/xx (ALU) -> GET_A.
//   - else illegal (see CONFIGURATION).
//  GET_A:   readnum=Rn, loada=1 -> GET_B.
//  GET_B:   readnum=Rm, loadb=1 -> ALU.
//  ALU:     asel=1 for MOV reg, else 0; shift=sh; loadc=1.
//   - op=01 (CMP): loads=1, loadc=0 -> WAIT (no write-back).
//   - otherwise -> WR_REG.
//  WR_REG:  writenum=Rd, vsel=00, write=1 -> WAIT.
//  WR_IMM:  writenum=Rn, vsel=01, write=1 -> WAIT.
//  Latency from s sampled high to w=1: MOV imm 3, MOV reg 5, ADD/AND/MVN 6, CMP 5 cycles.
//  Write strobe is asserted exactly one cycle per writing instruction; never in WAIT.
//  Back-to-back: s held high re-starts on the first cycle w=1; instr is re-sampled then.
// CONFIGURATION
//  REGSEQ_TRAP_EN defined:
//   - illegal opcode -> HALT state; err=1, w=0.
//   - leaves HALT only via reset_n=0.
//  REGSEQ_TRAP_EN undefined:
//   - illegal opcode -> WAIT next cycle (NOP, no strobes).
//   - no HALT state; err tied 0.
// STRUCTURE
//  Shared header regseq_defs.vh: state encodings (WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM, HALT),
//  opcode/op constants, vsel codes.
//  Sub-module regseq_decode: combinational IR field split + sign extension (sximm8); FSM stays in top.
// TESTING
//  1. Reset: reset_n=0 one edge -> w=1, write=0, all load strobes 0, state WAIT.
//  2. MOV imm: instr=16'hD205 (MOV R2,#5), s=1 -> 3rd cycle write=1, writenum=2, vsel=01, sximm8=16'h0005; then w=1.
//     Repeat with imm 8'hF0 -> sximm8=16'hFFF0.
//  3. ADD: instr=16'hA0A1 (ADD R5,R0,R1) -> readnum 0 with loada, then readnum 1 with loadb, loadc, then write R5; w after 6 cycles.
//  4. CMP: instr=16'hA902 (CMP R1,R2) -> loads=1 in ALU state, write never asserted, w=1 after 5 cycles.
//  5. Reset mid-op: ADD started, reset_n=0 in GET_B -> next cycle w=1, write never pulses.
//     s pulsed during busy -> ignored, IR unchanged.
//  6. Illegal instr=16'hE000:
//     - with REGSEQ_TRAP_EN: err=1, w=0 held until reset.
//     - without: w=1 two cycles after start, no strobes.

Source files
------------

// File: rtl/regfile_sequencer_pkg.sv
// Shared types and encodings for the register-file sequencer.
// The HALT state exists only when REGSEQ_TRAP_EN is defined.
package regfile_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_DECODE,
      ST_GET_A,
      ST_GET_B,
      ST_ALU,
      ST_WR_REG,
      ST_WR_IMM
`ifdef REGSEQ_TRAP_EN
      ,ST_HALT
`endif
   } state_t;

   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_ALU  = 3'b101;

   localparam logic [1:0] OP_MOVI  = 2'b10;
   localparam logic [1:0] OP_MOVR  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_CMP   = 2'b01;

   localparam logic [1:0] VSEL_C   = 2'b00;
   localparam logic [1:0] VSEL_IMM = 2'b01;

   // Field order matches IR[15:0] so a 16-bit IR maps directly onto it
   typedef struct packed {
      logic [2:0] opcode;
      logic [1:0] op;
      logic [2:0] rn;
      logic [2:0] rd;
      logic [1:0] sh;
      logic [2:0] rm;
   } ir_fields_t;

endpackage

// File: rtl/regfile_sequencer_if.sv
// Instruction handshake plus regfile/datapath control bundle of the sequencer.
interface regfile_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
);
   logic              s;
   logic [DATA_W-1:0] instr;
   logic              w;
   logic [REG_AW-1:0] readnum;
   logic [REG_AW-1:0] writenum;
   logic              write;
   logic              loada;
   logic              loadb;
   logic              loadc;
   logic              loads;
   logic              asel;
   logic              bsel;
   logic [1:0]        vsel;
   logic [1:0]        shift;
   logic [1:0]        alu_op;
   logic [DATA_W-1:0] sximm8;
   logic              err;

   modport master (
      output s, instr,
      input  w, readnum, writenum, write, loada, loadb, loadc, loads,
             asel, bsel, vsel, shift, alu_op, sximm8, err
   );

   modport slave (
      input  s, instr,
      output w, readnum, writenum, write, loada, loadb, loadc, loads,
             asel, bsel, vsel, shift, alu_op, sximm8, err
   );
endinterface

// File: rtl/regseq_decode.sv
// Combinational split of the instruction register into fields plus sign-extended imm8.
module regseq_decode
   import regfile_sequencer_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] ir,
   output ir_fields_t        f,
   output logic [DATA_W-1:0] sximm8
);

   assign f      = ir_fields_t'(ir[15:0]);
   assign sximm8 = {{(DATA_W-8){ir[7]}}, ir[7:0]};

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle controller stepping the regfile/ALU datapath through one instruction.
// Optional REGSEQ_TRAP_EN: illegal opcodes lock into HALT (err=1) until reset.
module regfile_sequencer
   import regfile_sequencer_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input logic               clk,
   input logic               reset_n,
   regfile_sequencer_if.slave bus
);

   state_t            state, state_nx;
   logic [DATA_W-1:0] ir;
   ir_fields_t        f;
   logic [DATA_W-1:0] sximm8;
   logic              mov_reg;

   regseq_decode #(.DATA_W(DATA_W)) u_decode (
      .ir     (ir),
      .f      (f),
      .sximm8 (sximm8)
   );

   assign bus.sximm8 = sximm8;
   assign mov_reg    = (f.opcode == OPC_MOV);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_WAIT;
         ir    <= '0;
      end else begin
         state <= state_nx;
         if (state == ST_WAIT && bus.s) ir <= bus.instr;
      end
   end

   always_comb begin
      state_nx     = state;
      bus.w        = 1'b0;
      bus.readnum  = '0;
      bus.writenum = '0;
      bus.write    = 1'b0;
      bus.loada    = 1'b0;
      bus.loadb    = 1'b0;
      bus.loadc    = 1'b0;
      bus.loads    = 1'b0;
      bus.asel     = 1'b0;
      bus.bsel     = 1'b0;
      bus.vsel     = VSEL_C;
      bus.shift    = 2'b00;
      bus.alu_op   = 2'b00;
      bus.err      = 1'b0;
      case (state)
         ST_WAIT: begin
            bus.w = 1'b1;
            if (bus.s) state_nx = ST_DECODE;
         end
         ST_DECODE: begin
            if (f.opcode == OPC_MOV && f.op == OP_MOVI)      state_nx = ST_WR_IMM;
            else if (f.opcode == OPC_MOV && f.op == OP_MOVR) state_nx = ST_GET_B;
            else if (f.opcode == OPC_ALU)                    state_nx = ST_GET_A;
`ifdef REGSEQ_TRAP_EN
            else                                             state_nx = ST_HALT;
`else
            else                                             state_nx = ST_WAIT;
`endif
         end
         ST_GET_A: begin
            bus.readnum = REG_AW'(f.rn);
            bus.loada   = 1'b1;
            state_nx    = ST_GET_B;
         end
         ST_GET_B: begin
            bus.readnum = REG_AW'(f.rm);
            bus.loadb   = 1'b1;
            state_nx    = ST_ALU;
         end
         ST_ALU: begin
            // MOV reg reuses the ADD path with A forced to zero; only ADD/MOV take a shift
            bus.asel   = mov_reg;
            bus.alu_op = mov_reg ? OP_ADD : f.op;
            bus.shift  = (mov_reg || f.op == OP_ADD) ? f.sh : 2'b00;
            if (!mov_reg && f.op == OP_CMP) begin
               bus.loads = 1'b1;
               state_nx  = ST_WAIT;
            end else begin
               bus.loadc = 1'b1;
               state_nx  = ST_WR_REG;
            end
         end
         ST_WR_REG: begin
            bus.writenum = REG_AW'(f.rd);
            bus.vsel     = VSEL_C;
            bus.write    = 1'b1;
            state_nx     = ST_WAIT;
         end
         ST_WR_IMM: begin
            bus.writenum = REG_AW'(f.rn);
            bus.vsel     = VSEL_IMM;
            bus.write    = 1'b1;
            state_nx     = ST_WAIT;
         end
`ifdef REGSEQ_TRAP_EN
         ST_HALT: begin
            bus.err  = 1'b1;
            state_nx = ST_HALT;
         end
`endif
         default: state_nx = ST_WAIT;
      endcase
   end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench: directed literal checks plus randomized traffic against a
// step-list model of each instruction. Honours REGSEQ_TRAP_EN if defined.
module tb_regfile_sequencer;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   regfile_sequencer_if #(.DATA_W(16), .REG_AW(3)) bus ();

   regfile_sequencer #(.DATA_W(16), .REG_AW(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct packed {
      logic        w;
      logic [2:0]  readnum;
      logic [2:0]  writenum;
      logic        write;
      logic        loada;
      logic        loadb;
      logic        loadc;
      logic        loads;
      logic        asel;
      logic        bsel;
      logic [1:0]  vsel;
      logic [1:0]  shift;
      logic [1:0]  alu_op;
      logic [15:0] sximm8;
      logic        err;
   } outv_t;

   int vectors     = 0;
   int miscompares = 0;

   // Model: each accepted instruction becomes a list of per-cycle output steps
   outv_t       plan_q[$];
   logic [15:0] m_ir         = '0;
   bit          m_valid      = 1'b0;
   bit          m_halted     = 1'b0;
   bit          m_halt_after = 1'b0;

   function automatic void build_plan(input logic [15:0] ir);
      logic [2:0] opc;
      logic [1:0] op;
      logic [1:0] sh;
      outv_t      v;
      opc = ir[15:13];
      op  = ir[12:11];
      sh  = ir[4:3];
      v = '0;
      plan_q.push_back(v);
      if (opc == 3'b110 && op == 2'b10) begin
         v = '0; v.writenum = ir[10:8]; v.vsel = 2'b01; v.write = 1'b1;
         plan_q.push_back(v);
      end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
         if (opc == 3'b101) begin
            v = '0; v.readnum = ir[10:8]; v.loada = 1'b1;
            plan_q.push_back(v);
         end
         v = '0; v.readnum = ir[2:0]; v.loadb = 1'b1;
         plan_q.push_back(v);
         v = '0;
         if (opc == 3'b110) begin
            v.asel = 1'b1; v.shift = sh; v.loadc = 1'b1;
         end else begin
            v.alu_op = op;
            v.shift  = (op == 2'b00) ? sh : 2'b00;
            if (op == 2'b01) v.loads = 1'b1;
            else             v.loadc = 1'b1;
         end
         plan_q.push_back(v);
         if (!(opc == 3'b101 && op == 2'b01)) begin
            v = '0; v.writenum = ir[7:5]; v.write = 1'b1;
            plan_q.push_back(v);
         end
      end else begin
`ifdef REGSEQ_TRAP_EN
         m_halt_after = 1'b1;
`else
         m_halt_after = 1'b0;
`endif
      end
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         plan_q.delete();
         m_ir         = '0;
         m_halted     = 1'b0;
         m_halt_after = 1'b0;
         m_valid      = 1'b1;
      end else if (m_valid && !m_halted) begin
         if (plan_q.size() == 0) begin
            if (bus.s) begin
               m_ir = bus.instr;
               build_plan(bus.instr);
            end
         end else begin
            void'(plan_q.pop_front());
            if (plan_q.size() == 0 && m_halt_after) begin
               m_halted     = 1'b1;
               m_halt_after = 1'b0;
            end
         end
      end
   end

   function automatic outv_t expected();
      outv_t v;
      v = '0;
      if (m_halted)                v.err = 1'b1;
      else if (plan_q.size() == 0) v.w   = 1'b1;
      else                         v     = plan_q[0];
      v.sximm8 = {{8{m_ir[7]}}, m_ir[7:0]};
      return v;
   endfunction

   always @(negedge clk) begin
      outv_t act, exp;
      if (m_valid) begin
         act = '{bus.w, bus.readnum, bus.writenum, bus.write, bus.loada, bus.loadb,
                 bus.loadc, bus.loads, bus.asel, bus.bsel, bus.vsel, bus.shift,
                 bus.alu_op, bus.sximm8, bus.err};
         exp = expected();
         vectors++;
         if (act !== exp) begin
            miscompares++;
            $display("FAIL cycle_cmp t=%0t actual=%h required=%h", $time, act, exp);
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [15:0] i);
      bus.s     = 1'b1;
      bus.instr = i;
      tick();
      bus.s     = 1'b0;
      bus.instr = 16'($urandom);
   endtask

   initial begin
      reset_n   = 1'b0;
      bus.s     = 1'b0;
      bus.instr = '0;
      tick();
      chk("rst_w",      16'(bus.w), 16'h1);
      chk("rst_write",  16'(bus.write), 16'h0);
      chk("rst_loads",  16'({bus.loada, bus.loadb, bus.loadc, bus.loads}), 16'h0);
      chk("rst_sximm8", bus.sximm8, 16'h0000);
      reset_n = 1'b1;
      tick();

      // MOV R2,#5 then MOV R2,#-16
      start(16'hD205);
      chk("movi_c1_w", 16'(bus.w), 16'h0);
      tick();
      chk("movi_write",    16'(bus.write), 16'h1);
      chk("movi_writenum", 16'(bus.writenum), 16'h2);
      chk("movi_vsel",     16'(bus.vsel), 16'h1);
      chk("movi_sximm8",   bus.sximm8, 16'h0005);
      tick();
      chk("movi_done_w",   16'(bus.w), 16'h1);
      start(16'hD2F0);
      tick();
      chk("movi_neg_sximm8", bus.sximm8, 16'hFFF0);
      chk("movi_neg_write",  16'(bus.write), 16'h1);
      tick();

      // ADD R5,R0,R1
      start(16'hA0A1);
      tick();
      chk("add_geta", 16'({bus.readnum, bus.loada}), 16'h1);
      tick();
      chk("add_getb", 16'({bus.readnum, bus.loadb}), 16'h3);
      tick();
      chk("add_loadc", 16'(bus.loadc), 16'h1);
      tick();
      chk("add_wr", 16'({bus.writenum, bus.write}), 16'hB);
      tick();
      chk("add_done_w", 16'(bus.w), 16'h1);

      // CMP R1,R2
      start(16'hA902);
      tick(); tick(); tick();
      chk("cmp_loads", 16'({bus.loads, bus.loadc, bus.write}), 16'h4);
      tick();
      chk("cmp_done_w", 16'({bus.w, bus.write}), 16'h2);

      // start pulse while busy must not disturb IR
      start(16'hA0A1);
      tick();
      bus.s     = 1'b1;
      bus.instr = 16'hD2F0;
      tick();
      bus.s     = 1'b0;
      tick(); tick();
      chk("busy_s_writenum", 16'(bus.writenum), 16'h5);
      chk("busy_s_sximm8",   bus.sximm8, 16'hFFA1);
      tick();

      // reset while in GET_B
      start(16'hA0A1);
      tick(); tick();
      reset_n = 1'b0;
      tick();
      chk("midrst_w", 16'({bus.w, bus.write}), 16'h2);
      reset_n = 1'b1;
      tick();
      chk("midrst_idle", 16'({bus.w, bus.write}), 16'h2);

      // illegal opcode
      start(16'hE000);
      chk("ill_c1_w", 16'(bus.w), 16'h0);
      tick();
`ifdef REGSEQ_TRAP_EN
      repeat (4) begin
         chk("ill_halt", 16'({bus.err, bus.w}), 16'h2);
         tick();
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
`else
      chk("ill_nop", 16'({bus.w, bus.err, bus.write}), 16'h4);
      tick();
`endif

      // randomized traffic
      repeat (3000) begin
         reset_n = ($urandom_range(0, 99) != 0);
         bus.s   = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       bus.instr = {3'b110, 2'b10, 11'($urandom)};
            1:       bus.instr = {3'b110, 2'b00, 11'($urandom)};
            2:       bus.instr = {3'b101, 13'($urandom)};
            default: bus.instr = 16'($urandom);
         endcase
         tick();
      end
      reset_n = 1'b1;
      bus.s   = 1'b0;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
